// File: rtl/data_array_arbiter_pkg.sv
// Shared definitions for the data array arbiter: grant-source encoding,
// port-A access mode constants and small decode helpers.
package data_array_arbiter_pkg;

  // Which requester owns data array port A in the current cycle
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    CORE_RD = 3'd1,
    CORE_WR = 3'd2,
    FILL    = 3'd3,
    EVICT   = 3'd4
  } gnt_src_e;

  // Port-A access width: single word or full line
  localparam logic WORD = 1'b0;
  localparam logic LINE = 1'b1;

  // Width of the core starvation counter (saturates at all-ones)
  localparam int STARVE_CTR_W = 3;

  // Map a core request to its grant source from the write enable
  function automatic gnt_src_e core_src(input logic we);
    return we ? CORE_WR : CORE_RD;
  endfunction

  // True for grant sources that write the array (these open a hazard window)
  function automatic logic is_write(input gnt_src_e src);
    return (src == CORE_WR) || (src == FILL);
  endfunction

  // True for grant sources that belong to the core requester
  function automatic logic is_core(input gnt_src_e src);
    return (src == CORE_RD) || (src == CORE_WR);
  endfunction

endpackage

// File: rtl/data_array_arbiter_if.sv
// Bus bundle between the three requesters (core, fill, evict), the
// arbiter and data array port A. The arbiter sits on the slave side.
interface data_array_arbiter_if
  import data_array_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int INDEX_WIDTH = 9,
  parameter int WORD_BITS   = 3
);

  localparam int W = DATA_WIDTH >> WORD_BITS;

  // core word access
  logic                   core_req;
  logic                   core_we;
  logic [INDEX_WIDTH-1:0] core_index;
  logic [WORD_BITS-1:0]   core_word;
  logic [W-1:0]           core_wdata;
  logic                   core_gnt;
  logic                   core_rvalid;
  logic [W-1:0]           core_rdata;

  // full-line fill (write)
  logic                   fill_req;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [DATA_WIDTH-1:0]  fill_data;
  logic                   fill_gnt;

  // full-line evict (read)
  logic                   evict_req;
  logic [INDEX_WIDTH-1:0] evict_index;
  logic                   evict_gnt;
  logic                   evict_rvalid;
  logic [DATA_WIDTH-1:0]  evict_rdata;

  // data array port A
  logic [INDEX_WIDTH-1:0] arr_addr_a;
  logic [WORD_BITS-1:0]   arr_word_a;
  logic [DATA_WIDTH-1:0]  arr_data_a;
  logic                   arr_we_a;
  logic                   arr_mode_a;
  logic [DATA_WIDTH-1:0]  arr_q_a;

  // Arbiter side
  modport slave (
    input  core_req, core_we, core_index, core_word, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  fill_req, fill_index, fill_data,
    output fill_gnt,
    input  evict_req, evict_index,
    output evict_gnt, evict_rvalid, evict_rdata,
    output arr_addr_a, arr_word_a, arr_data_a, arr_we_a, arr_mode_a,
    input  arr_q_a
  );

  // Requester / array side
  modport master (
    output core_req, core_we, core_index, core_word, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output fill_req, fill_index, fill_data,
    input  fill_gnt,
    output evict_req, evict_index,
    input  evict_gnt, evict_rvalid, evict_rdata,
    input  arr_addr_a, arr_word_a, arr_data_a, arr_we_a, arr_mode_a,
    output arr_q_a
  );

endinterface

// File: rtl/data_array_arbiter_starve_ctr.sv
// Core starvation counter: counts consecutive cycles in which the core is
// requesting but not granted, and raises promote once the limit is hit so
// the core wins the next arbitration.
module arb_starve_ctr
  import data_array_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic core_req,
  input  logic core_gnt,
  output logic promote
);

  logic [STARVE_CTR_W-1:0] cnt;

  // Saturating count of denied core cycles; any grant or dropped request restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (core_gnt || !core_req) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign promote = (int'(cnt) >= STARVE_LIMIT);

endmodule

// File: rtl/data_array_arbiter.sv
// Single-port data array arbiter. Picks one of fill, evict and core per
// cycle (fill > evict > core, unless the core has starved), drives array
// port A for the winner, blocks reads of a line written in the previous
// cycle, and returns read data one cycle after each read grant.
module data_array_arbiter
  import data_array_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int INDEX_WIDTH  = 9,
  parameter int WORD_BITS    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  data_array_arbiter_if.slave bus
);

  localparam int W = DATA_WIDTH >> WORD_BITS;

  gnt_src_e               sel;
  logic                   promote;
  logic                   core_gnt_c;
  logic                   core_ok;
  logic                   evict_ok;

  // last-cycle write tracking for the write-then-read hazard
  logic                   hz_valid;
  logic [INDEX_WIDTH-1:0] hz_index;

  // read return pipeline
  logic                   core_rvalid_q;
  logic                   evict_rvalid_q;
  logic [WORD_BITS-1:0]   rd_word_q;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .core_req (bus.core_req),
    .core_gnt (core_gnt_c),
    .promote  (promote)
  );

  // Eligibility: a read of the line written last cycle must wait one cycle
  always_comb begin
    core_ok  = bus.core_req &&
               (bus.core_we || !(hz_valid && (hz_index == bus.core_index)));
    evict_ok = bus.evict_req && !(hz_valid && (hz_index == bus.evict_index));
  end

  // Grant selection; nothing is granted while reset is applied
  always_comb begin
    sel = NONE;
    if (!rst) begin
      if (promote && core_ok) begin
        sel = core_src(bus.core_we);
      end else if (bus.fill_req) begin
        sel = FILL;
      end else if (evict_ok) begin
        sel = EVICT;
      end else if (core_ok) begin
        sel = core_src(bus.core_we);
      end
    end
  end

  // Grant strobes and port-A drive for the selected requester
  always_comb begin
    core_gnt_c     = is_core(sel);
    bus.core_gnt   = core_gnt_c;
    bus.fill_gnt   = (sel == FILL);
    bus.evict_gnt  = (sel == EVICT);
    bus.arr_addr_a = '0;
    bus.arr_word_a = '0;
    bus.arr_data_a = '0;
    bus.arr_we_a   = 1'b0;
    bus.arr_mode_a = WORD;
    case (sel)
      CORE_WR: begin
        bus.arr_addr_a = bus.core_index;
        bus.arr_word_a = bus.core_word;
        bus.arr_data_a = DATA_WIDTH'(bus.core_wdata);
        bus.arr_we_a   = 1'b1;
        bus.arr_mode_a = WORD;
      end
      CORE_RD: begin
        bus.arr_addr_a = bus.core_index;
        bus.arr_word_a = bus.core_word;
        bus.arr_mode_a = WORD;
      end
      FILL: begin
        bus.arr_addr_a = bus.fill_index;
        bus.arr_data_a = bus.fill_data;
        bus.arr_we_a   = 1'b1;
        bus.arr_mode_a = LINE;
      end
      EVICT: begin
        bus.arr_addr_a = bus.evict_index;
        bus.arr_mode_a = LINE;
      end
      default: begin
      end
    endcase
  end

  // Remember the line written this cycle so next cycle's reads of it are held off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_valid <= 1'b0;
      hz_index <= '0;
    end else begin
      hz_valid <= is_write(sel);
      hz_index <= (sel == FILL) ? bus.fill_index : bus.core_index;
    end
  end

  // Read return pipeline: one valid per read grant, one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rvalid_q  <= 1'b0;
      evict_rvalid_q <= 1'b0;
      rd_word_q      <= '0;
    end else begin
      core_rvalid_q  <= (sel == CORE_RD);
      evict_rvalid_q <= (sel == EVICT);
      if (sel == CORE_RD) begin
        rd_word_q <= bus.core_word;
      end
    end
  end

  // Return data comes straight from the array output, zeroed outside valid
  always_comb begin
    bus.core_rvalid  = core_rvalid_q;
    bus.evict_rvalid = evict_rvalid_q;
    bus.core_rdata   = core_rvalid_q ? bus.arr_q_a[int'(rd_word_q) * W +: W] : '0;
    bus.evict_rdata  = evict_rvalid_q ? bus.arr_q_a : '0;
  end

endmodule

// File: tb/tb_data_array_arbiter.sv
// Self-checking bench for data_array_arbiter: a behavioural array on port A,
// a transaction-level reference model, directed scenarios and random traffic.
module tb_data_array_arbiter;

  localparam int DW    = 256;
  localparam int IW    = 9;
  localparam int WB    = 3;
  localparam int W     = DW >> WB;
  localparam int LIMIT = 4;
  localparam int NLINE = 1 << IW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_array_arbiter_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB)) bus ();

  data_array_arbiter #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural data array: registered read, word or line write, cleared by reset
  logic [DW-1:0] arr_mem [0:NLINE-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLINE; i++) arr_mem[i] <= '0;
      bus.arr_q_a <= '0;
    end else begin
      bus.arr_q_a <= arr_mem[bus.arr_addr_a];
      if (bus.arr_we_a) begin
        if (bus.arr_mode_a) arr_mem[bus.arr_addr_a] <= bus.arr_data_a;
        else arr_mem[bus.arr_addr_a][int'(bus.arr_word_a) * W +: W] <= bus.arr_data_a[W-1:0];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:NLINE-1];
  int            starve;
  bit            hz_v;
  int            hz_idx;
  bit            exp_core_v;
  logic [W-1:0]  exp_core_d;
  bit            exp_ev_v;
  logic [DW-1:0] exp_ev_d;

  int n_vec = 0;
  int n_err = 0;

  logic          obs_core_gnt, obs_fill_gnt, obs_evict_gnt;
  logic          obs_core_rvalid, obs_evict_rvalid;
  logic [W-1:0]  obs_core_rdata;
  logic [DW-1:0] obs_evict_rdata;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] randLine();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic modelReset();
    starve     = 0;
    hz_v       = 0;
    hz_idx     = 0;
    exp_core_v = 0;
    exp_core_d = '0;
    exp_ev_v   = 0;
    exp_ev_d   = '0;
    for (int i = 0; i < NLINE; i++) ref_mem[i] = '0;
  endtask

  // Winner by the rules: starved core first, then fill, evict, core; reads of
  // last cycle's written line are not eligible. 0 none, 1 core, 2 fill, 3 evict.
  function automatic int modelPick();
    bit core_can, evict_can;
    core_can  = bus.core_req && (bus.core_we || !(hz_v && hz_idx == int'(bus.core_index)));
    evict_can = bus.evict_req && !(hz_v && hz_idx == int'(bus.evict_index));
    if (core_can && starve >= LIMIT) return 1;
    if (bus.fill_req) return 2;
    if (evict_can) return 3;
    if (core_can) return 1;
    return 0;
  endfunction

  task automatic modelUpdate(input int pick);
    exp_core_v = 0;
    exp_core_d = '0;
    exp_ev_v   = 0;
    exp_ev_d   = '0;
    if (pick == 1 && !bus.core_we) begin
      exp_core_v = 1;
      exp_core_d = ref_mem[bus.core_index][int'(bus.core_word) * W +: W];
    end
    if (pick == 3) begin
      exp_ev_v = 1;
      exp_ev_d = ref_mem[bus.evict_index];
    end
    hz_v = 0;
    if (pick == 2) begin
      ref_mem[bus.fill_index] = bus.fill_data;
      hz_v   = 1;
      hz_idx = int'(bus.fill_index);
    end
    if (pick == 1 && bus.core_we) begin
      ref_mem[bus.core_index][int'(bus.core_word) * W +: W] = bus.core_wdata;
      hz_v   = 1;
      hz_idx = int'(bus.core_index);
    end
    if (pick == 1 || !bus.core_req) starve = 0;
    else if (starve < 7) starve++;
  endtask

  // One clock cycle: sample and check at the falling edge, then advance the
  // model and retire granted requests just after the rising edge.
  task automatic applyStimulus(input bit late_rst);
    int            pick;
    logic          e_we, e_mode, chk_word, chk_data;
    logic [IW-1:0] e_addr;
    logic [WB-1:0] e_word;
    logic [DW-1:0] e_data;
    @(negedge clk);
    obs_core_gnt     = bus.core_gnt;
    obs_fill_gnt     = bus.fill_gnt;
    obs_evict_gnt    = bus.evict_gnt;
    obs_core_rvalid  = bus.core_rvalid;
    obs_evict_rvalid = bus.evict_rvalid;
    obs_core_rdata   = bus.core_rdata;
    obs_evict_rdata  = bus.evict_rdata;
    if (rst) begin
      checkOutput("rst_core_gnt", bus.core_gnt, '0);
      checkOutput("rst_fill_gnt", bus.fill_gnt, '0);
      checkOutput("rst_evict_gnt", bus.evict_gnt, '0);
      checkOutput("rst_core_rvalid", bus.core_rvalid, '0);
      checkOutput("rst_evict_rvalid", bus.evict_rvalid, '0);
      checkOutput("rst_core_rdata", bus.core_rdata, '0);
      checkOutput("rst_evict_rdata", bus.evict_rdata, '0);
      checkOutput("rst_arr_we", bus.arr_we_a, '0);
      modelReset();
      @(posedge clk);
      #1;
    end else begin
      pick = modelPick();
      checkOutput("core_gnt", bus.core_gnt, DW'(pick == 1));
      checkOutput("fill_gnt", bus.fill_gnt, DW'(pick == 2));
      checkOutput("evict_gnt", bus.evict_gnt, DW'(pick == 3));
      checkOutput("core_rvalid", bus.core_rvalid, DW'(exp_core_v));
      checkOutput("core_rdata", bus.core_rdata, DW'(exp_core_d));
      checkOutput("evict_rvalid", bus.evict_rvalid, DW'(exp_ev_v));
      checkOutput("evict_rdata", bus.evict_rdata, exp_ev_d);
      e_we = 0; e_mode = 0; e_addr = '0; e_word = '0; e_data = '0;
      chk_word = 1; chk_data = 1;
      case (pick)
        1: begin
          e_we = bus.core_we; e_addr = bus.core_index; e_word = bus.core_word;
          e_data = DW'(bus.core_wdata); chk_data = bus.core_we;
        end
        2: begin
          e_we = 1; e_mode = 1; e_addr = bus.fill_index; e_data = bus.fill_data; chk_word = 0;
        end
        3: begin
          e_mode = 1; e_addr = bus.evict_index; chk_word = 0; chk_data = 0;
        end
        default: begin
        end
      endcase
      checkOutput("arr_we_a", bus.arr_we_a, DW'(e_we));
      checkOutput("arr_mode_a", bus.arr_mode_a, DW'(e_mode));
      checkOutput("arr_addr_a", bus.arr_addr_a, DW'(e_addr));
      if (chk_word) checkOutput("arr_word_a", bus.arr_word_a, DW'(e_word));
      if (chk_data) checkOutput("arr_data_a", bus.arr_data_a, e_data);
      if (late_rst) begin
        #2;
        rst = 1'b1;
      end else begin
        modelUpdate(pick);
      end
      @(posedge clk);
      #1;
      if (late_rst) begin
        modelReset();
        bus.core_req = 0; bus.fill_req = 0; bus.evict_req = 0;
      end else begin
        if (pick == 1) bus.core_req = 0;
        if (pick == 2) bus.fill_req = 0;
        if (pick == 3) bus.evict_req = 0;
      end
    end
  endtask

  task automatic setCore(input bit we, input int idx, input int word, input logic [W-1:0] wd);
    bus.core_req = 1; bus.core_we = we; bus.core_index = IW'(idx);
    bus.core_word = WB'(word); bus.core_wdata = wd;
  endtask

  task automatic setFill(input int idx, input logic [DW-1:0] d);
    bus.fill_req = 1; bus.fill_index = IW'(idx); bus.fill_data = d;
  endtask

  task automatic setEvict(input int idx);
    bus.evict_req = 1; bus.evict_index = IW'(idx);
  endtask

  logic [DW-1:0] pat_half, line9, exp_line, line7;

  initial begin
    rst = 1'b1;
    bus.core_req = 0; bus.core_we = 0; bus.core_index = '0; bus.core_word = '0; bus.core_wdata = '0;
    bus.fill_req = 0; bus.fill_index = '0; bus.fill_data = '0;
    bus.evict_req = 0; bus.evict_index = '0;
    modelReset();

    // requests present during reset are held off; first grant right after release
    setCore(0, 3, 1, '0);
    setEvict(2);
    applyStimulus(0);
    applyStimulus(0);
    rst = 1'b0;
    applyStimulus(0);
    checkOutput("r022_first_gnt", obs_evict_gnt, 1);
    applyStimulus(0);
    applyStimulus(0);
    applyStimulus(0);

    // all three together: fill, then evict, then core
    setFill(1, randLine());
    setEvict(2);
    setCore(0, 3, 4, '0);
    applyStimulus(0);
    checkOutput("r025_c0_fill", obs_fill_gnt, 1);
    applyStimulus(0);
    checkOutput("r025_c1_evict", obs_evict_gnt, 1);
    applyStimulus(0);
    checkOutput("r025_c2_core", obs_core_gnt, 1);
    checkOutput("r025_c2_ev_rvalid", obs_evict_rvalid, 1);
    applyStimulus(0);

    // fill then core read of the same line: one-cycle hold-off
    pat_half = {{(DW/2){1'b0}}, {(DW/2){1'b1}}};
    setFill(5, pat_half);
    setCore(0, 5, 7, '0);
    applyStimulus(0);
    checkOutput("r026_fill", obs_fill_gnt, 1);
    applyStimulus(0);
    checkOutput("r026_withheld", obs_core_gnt, 0);
    applyStimulus(0);
    checkOutput("r026_gnt", obs_core_gnt, 1);
    applyStimulus(0);
    checkOutput("r026_rvalid", obs_core_rvalid, 1);
    checkOutput("r026_rdata", obs_core_rdata, DW'(pat_half[DW-1 -: W]));

    // core word write merges into a line, evict reads it back
    line9 = randLine();
    setFill(9, line9);
    applyStimulus(0);
    setCore(1, 9, 2, 32'hDEADBEEF);
    applyStimulus(0);
    checkOutput("r027_wr_gnt", obs_core_gnt, 1);
    setEvict(9);
    applyStimulus(0);
    checkOutput("r027_ev_hazard", obs_evict_gnt, 0);
    applyStimulus(0);
    checkOutput("r027_ev_gnt", obs_evict_gnt, 1);
    applyStimulus(0);
    exp_line = line9;
    exp_line[95:64] = 32'hDEADBEEF;
    checkOutput("r027_word2", DW'(obs_evict_rdata[95:64]), DW'(32'hDEADBEEF));
    checkOutput("r027_line", obs_evict_rdata, exp_line);

    // continuous fill starves the core for exactly four cycles
    setCore(0, 100, 1, '0);
    for (int i = 0; i < 6; i++) begin
      if (!bus.fill_req) setFill(200, randLine());
      applyStimulus(0);
      checkOutput($sformatf("r028_core_gnt_%0d", i), obs_core_gnt, DW'(i == 4));
      checkOutput($sformatf("r028_fill_gnt_%0d", i), obs_fill_gnt, DW'(i != 4));
    end
    bus.fill_req = 0;
    applyStimulus(0);
    applyStimulus(0);

    // four back-to-back core reads return in order on consecutive cycles
    line7 = randLine();
    setFill(7, line7);
    applyStimulus(0);
    applyStimulus(0);
    for (int i = 0; i < 4; i++) begin
      setCore(0, 7, i, '0);
      applyStimulus(0);
      checkOutput($sformatf("r030_gnt_%0d", i), obs_core_gnt, 1);
      if (i > 0) begin
        checkOutput($sformatf("r030_rvalid_%0d", i - 1), obs_core_rvalid, 1);
        checkOutput($sformatf("r030_rdata_%0d", i - 1), DW'(obs_core_rdata), DW'(line7[(i-1)*W +: W]));
      end
    end
    applyStimulus(0);
    checkOutput("r030_rvalid_3", obs_core_rvalid, 1);
    checkOutput("r030_rdata_3", DW'(obs_core_rdata), DW'(line7[3*W +: W]));

    // reset lands right after a core read grant: no read return
    setCore(0, 7, 5, '0);
    applyStimulus(1);
    checkOutput("r029_gnt", obs_core_gnt, 1);
    setFill(3, randLine());
    setEvict(4);
    applyStimulus(0);
    checkOutput("r029_rvalid", obs_core_rvalid, 0);
    applyStimulus(0);
    rst = 1'b0;
    applyStimulus(0);
    checkOutput("r029_first_gnt", obs_fill_gnt, 1);
    applyStimulus(0);
    applyStimulus(0);

    // random traffic on a few lines to provoke hazards and starvation
    for (int c = 0; c < 800; c++) begin
      if (!bus.fill_req && $urandom_range(0, 3) == 0)
        setFill(int'($urandom_range(0, 3)), randLine());
      if (!bus.evict_req && $urandom_range(0, 2) == 0)
        setEvict(int'($urandom_range(0, 3)));
      if (!bus.core_req && $urandom_range(0, 1) == 0)
        setCore(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)), W'($urandom()));
      else if (bus.core_req && $urandom_range(0, 15) == 0)
        bus.core_req = 0;
      applyStimulus(0);
    end

    bus.core_req = 0; bus.fill_req = 0; bus.evict_req = 0;
    applyStimulus(0);
    applyStimulus(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_array_arbiter.md
DATA_ARRAY_ARBITER -- requirements
Module: data_array_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line: DATA_WIDTH, 256, full line width; INDEX_WIDTH, 9, set index bits; WORD_BITS, 3, word-select bits; STARVE_LIMIT, 4, consecutive core denials before core is promoted. Word width W = DATA_WIDTH/2**WORD_BITS.
REQ-002 clk  in  1  single clock for all state.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 core_req / core_we / core_index / core_word / core_wdata  in  1/1/INDEX_WIDTH/WORD_BITS/W  core word access request.
REQ-005 core_gnt  out  1  core request accepted this cycle; core_rvalid  out  1  core read data valid; core_rdata  out  W  selected word.
REQ-006 fill_req / fill_index / fill_data  in  1/INDEX_WIDTH/DATA_WIDTH  full-line write request; fill_gnt  out  1.
REQ-007 evict_req / evict_index  in  1/INDEX_WIDTH  full-line read request; evict_gnt  out  1; evict_rvalid  out  1; evict_rdata  out  DATA_WIDTH.
REQ-008 arr_addr_a / arr_word_a / arr_data_a / arr_we_a / arr_mode_a  out  INDEX_WIDTH/WORD_BITS/DATA_WIDTH/1/1  drive data array port A; arr_q_a  in  DATA_WIDTH  port A read data, one cycle after address.

Function
REQ-009 At most one grant per cycle; a grant is combinational from the current requests and registered state; a request is consumed on the rising edge where req and gnt are both high.
REQ-010 Default priority: fill > evict > core.
REQ-011 A 3-bit saturating starve counter increments on each cycle with core_req high and core_gnt low, and clears on core_gnt; when it reaches STARVE_LIMIT, core has top priority for the next cycle.
REQ-012 Core write grant: arr_mode_a=0, arr_we_a=1, arr_word_a=core_word, arr_data_a[W-1:0]=core_wdata, upper bits 0.
REQ-013 Core read grant: arr_mode_a=0, arr_we_a=0; core_rvalid high exactly one cycle later with core_rdata = word core_word (registered at grant) of arr_q_a.
REQ-014 Fill grant: arr_mode_a=1, arr_we_a=1, arr_data_a=fill_data, arr_addr_a=fill_index.
REQ-015 Evict grant: arr_mode_a=1, arr_we_a=0; evict_rvalid high exactly one cycle later with evict_rdata=arr_q_a.
REQ-016 With no grant: arr_we_a=0, arr_mode_a=0, arr_addr_a/arr_word_a/arr_data_a=0.
REQ-017 Write-read hazard: in the cycle after any granted write to index X, no read of index X is granted (core or evict); that requester waits one cycle while other requesters may be granted.
REQ-018 Reads are pipelined: back-to-back read grants on consecutive cycles produce rvalid on consecutive cycles, one per grant, in order.
REQ-019 Requesters hold req and payload stable until granted; req deasserted before grant is legal and leaves no state change except starve counter clearing when core_req drops.
REQ-020 rvalid pulses are not back-pressured; consumers take data in the rvalid cycle.

Reset
REQ-021 On rst high, immediately and while held: all gnt and rvalid outputs 0, core_rdata 0, evict_rdata 0, starve counter 0, hazard register invalid, arr_we_a 0.
REQ-022 A read granted in the cycle rst asserts produces no rvalid; the first grant is possible in the first cycle after rst deasserts.

Structure
REQ-023 Shared package holds the grant-source encoding (NONE, CORE_RD, CORE_WR, FILL, EVICT) and the port-A mode constants (WORD=0, LINE=1).
REQ-024 One sub-module, arb_starve_ctr (saturating starve counter with promote output); the remainder is flat.

Verification
REQ-025 fill_req, evict_req and core_req high together -> fill_gnt in cycle 0, evict_gnt in cycle 1, core_gnt in cycle 2; evict_rvalid in cycle 2.
REQ-026 Fill 0x0..0FF..FF to index 5 with core read of index 5 word 7 pending -> core_gnt withheld in the cycle after fill, granted the next; core_rvalid one cycle later with core_rdata = 0x0..0FF..FF bits [255:224].
REQ-027 Core write word 2 = 0xDEADBEEF at index 9, then evict index 9 -> evict_rdata[95:64] = 0xDEADBEEF, other words unchanged.
REQ-028 fill_req held continuously with core_req high -> core_gnt after exactly 4 denied cycles, then fill resumes.
REQ-029 Core read granted, rst asserted in the following cycle -> core_rvalid stays 0, all outputs 0 during reset.
REQ-030 Four back-to-back core reads of words 0..3 -> four consecutive core_rvalid pulses with data in request order.
